// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Debounces one active-low pushbutton. The raw key goes through a two-flop
// synchronizer. A four-state FSM then accepts a level change only after the
// synchronized key has been stable for DEBOUNCE_CYCLES clocks. Each accepted
// press produces a one-clock strobe and increments a wrapping 4-bit counter.
//
// Optional feature (macro KEY_AUTOREPEAT_EN):
//   While the key stays HELD, the block issues a further strobe and count
//   increment every REPEAT_CYCLES clocks. With the macro undefined, no repeat
//   logic is built and each accepted press gives exactly one strobe.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable clocks needed to accept a level change (>= 2)
//   REPEAT_CYCLES   : held-key repeat period in clocks (>= 2, autorepeat only)
//
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   KEY[1:0]    in   KEY[1] = asynchronous active-low reset,
//                    KEY[0] = raw active-low pushbutton (asynchronous)
//   key_pressed out  debounced level, 1 = held
//   press_pulse out  one-clock strobe per accepted press (and per repeat)
//   press_count out  number of strobes issued, wraps 15 -> 0
//   state_dbg   out  FSM state: 00 IDLE, 01 PRESS_WAIT, 10 HELD,
//                    11 RELEASE_WAIT
//
// Handshake: none. press_pulse is a plain single-cycle enable with no
// back-pressure. A downstream stage samples it on the rising edge that
// follows the one that set it. It is never high on two consecutive clocks.
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       CLOCK_50,
  input  logic [1:0] KEY,
  output logic       key_pressed,
  output logic       press_pulse,
  output logic [3:0] press_count,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'b00,
    S_PRESS_WAIT   = 2'b01,
    S_HELD         = 2'b10,
    S_RELEASE_WAIT = 2'b11
  } state_t;

  logic          w_rst_n;
  logic          r_sync1;
  logic          r_key_s;
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_release;
  logic          w_rep_fire;
  logic          w_strobe;
  logic          w_key_pressed_nxt;
  logic          r_key_pressed;
  logic          r_press_pulse;
  logic [3:0]    r_press_count;

  assign w_rst_n = KEY[1];

  // Two-flop synchronizer. Its reset value is 1, the key-released level.
  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync1 <= 1'b1;
      r_key_s <= 1'b1;
    end else begin
      r_sync1 <= KEY[0];
      r_key_s <= r_sync1;
    end
  end

  // FSM process 1: state register
  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // FSM process 2: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!r_key_s) w_next = S_PRESS_WAIT;
      end
      S_PRESS_WAIT: begin
        if (r_key_s)              w_next = S_IDLE;
        else if (r_cnt == CNT_LAST) w_next = S_HELD;
      end
      S_HELD: begin
        if (r_key_s) w_next = S_RELEASE_WAIT;
      end
      S_RELEASE_WAIT: begin
        if (!r_key_s)             w_next = S_HELD;
        else if (r_cnt == CNT_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The debounce counter restarts on every state entry. It counts only in
  // the two wait states and sits at 0 elsewhere.
  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if ((r_state == S_PRESS_WAIT) || (r_state == S_RELEASE_WAIT)) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] r_rep;

  // The repeat counter runs only while the FSM stays in HELD. Any transition,
  // including entry to HELD from RELEASE_WAIT, restarts the period. A repeat
  // fires only if the FSM remains in HELD on that clock, so a release being
  // detected does not also produce a last repeat.
  assign w_rep_fire = (r_state == S_HELD) && (w_next == S_HELD) &&
                      (r_rep == REP_LAST);

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rep <= '0;
    end else if ((r_state != S_HELD) || (w_next != S_HELD) || w_rep_fire) begin
      r_rep <= '0;
    end else begin
      r_rep <= r_rep + RW'(1);
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // FSM process 3: output decode. The results are registered below so that
  // every port is driven from a flop.
  always_comb begin
    w_accept          = (r_state == S_PRESS_WAIT)   && (w_next == S_HELD);
    w_release         = (r_state == S_RELEASE_WAIT) && (w_next == S_IDLE);
    w_strobe          = w_accept || w_rep_fire;
    w_key_pressed_nxt = r_key_pressed;
    if (w_accept)       w_key_pressed_nxt = 1'b1;
    else if (w_release) w_key_pressed_nxt = 1'b0;
  end

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_key_pressed <= 1'b0;
      r_press_pulse <= 1'b0;
      r_press_count <= 4'd0;
    end else begin
      r_key_pressed <= w_key_pressed_nxt;
      r_press_pulse <= w_strobe;
      if (w_strobe) r_press_count <= r_press_count + 4'd1;
    end
  end

  assign key_pressed = r_key_pressed;
  assign press_pulse = r_press_pulse;
  assign press_count = r_press_count;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//
// Bench for key_debounce with DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=8.
//
// Edge numbering: edge 0 is the first rising edge that samples KEY[0] low.
// Outputs are sampled 1 ns after each edge.
// With a clean press, the FSM enters HELD on edge 6 (the 7th edge). That same
// edge registers press_pulse, so a downstream stage sees the pulse on edge 7.
// Release follows the same timeline.
//
// The bench is built with the same KEY_AUTOREPEAT_EN setting as the DUT.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_debounce;

  localparam int DC = 4;
  localparam int RC = 8;

  logic       clk;
  logic [1:0] key;
  logic       key_pressed;
  logic       press_pulse;
  logic [3:0] press_count;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;

  // Per-scenario pulse monitor state, updated by tick()
  int edge_n;
  int strobes;
  int consec;
  logic prev_pulse;
  int s_edges[$];

  typedef struct {
    logic       key0;
    logic       exp_pulse;
    logic       exp_pressed;
    logic [3:0] exp_count;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[16];

  key_debounce #(.DEBOUNCE_CYCLES(DC), .REPEAT_CYCLES(RC)) dut (
    .CLOCK_50    (clk),
    .KEY         (key),
    .key_pressed (key_pressed),
    .press_pulse (press_pulse),
    .press_count (press_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (press_pulse === 1'b1) begin
      strobes++;
      s_edges.push_back(edge_n);
      if (prev_pulse === 1'b1) consec++;
    end
    prev_pulse = press_pulse;
    edge_n++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic mon_clear();
    edge_n = 0;
    strobes = 0;
    consec = 0;
    prev_pulse = 1'b0;
    s_edges.delete();
  endtask

  task automatic do_reset();
    key[0] = 1'b1;
    #2 key[1] = 1'b0;
    ticks(2);
    key[1] = 1'b1;
    ticks(3);
  endtask

  task automatic press_once();
    key[0] = 1'b0;
    ticks(10);
    key[0] = 1'b1;
    ticks(10);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Clean press then clean release, from IDLE with press_count=0
    //            key0 pulse pressed count state
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'd0, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'd0, 2'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'd0, 2'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd0, 2'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, 2'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'd0, 2'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'd1, 2'd2};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'd1, 2'd2};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'd1, 2'd2};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'd1, 2'd2};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 4'd1, 2'd2};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 4'd1, 2'd3};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 4'd1, 2'd3};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 4'd1, 2'd3};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 4'd1, 2'd3};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 4'd1, 2'd0};

    mon_clear();
    key = 2'b01;   // in reset, key released
    #3;
    chk("rst_pressed", {31'd0, key_pressed}, 32'd0);
    chk("rst_pulse",   {31'd0, press_pulse}, 32'd0);
    chk("rst_count",   {28'd0, press_count}, 32'd0);
    chk("rst_state",   {30'd0, state_dbg},   32'd0);
    ticks(2);
    key[1] = 1'b1;
    ticks(3);

    // --- table-driven clean press / release ---
    for (int e = 0; e < 16; e++) begin
      key[0] = vecs[e].key0;
      tick();
      chk($sformatf("vec%0d_pulse", e),   {31'd0, press_pulse}, {31'd0, vecs[e].exp_pulse});
      chk($sformatf("vec%0d_pressed", e), {31'd0, key_pressed}, {31'd0, vecs[e].exp_pressed});
      chk($sformatf("vec%0d_count", e),   {28'd0, press_count}, {28'd0, vecs[e].exp_count});
      chk($sformatf("vec%0d_state", e),   {30'd0, state_dbg},   {30'd0, vecs[e].exp_state});
    end
    ticks(3);

    // --- press bounce: low 2, high 1, then low (final fall at edge 3) ---
    mon_clear();
    key[0] = 1'b0; ticks(2);
    key[0] = 1'b1; ticks(1);
    key[0] = 1'b0; ticks(12);
    chk("bounce_strobes", strobes, 1);
    if (s_edges.size() > 0) chk("bounce_edge", s_edges[0], 9);
    else chk("bounce_edge_missing", 0, 1);
    chk("bounce_count", {28'd0, press_count}, 32'd2);
    chk("bounce_held", {30'd0, state_dbg}, 32'd2);

    // --- release bounce while HELD: high 2 clocks then low ---
    begin
      logic saw_rw;
      logic dropped;
      saw_rw = 1'b0;
      dropped = 1'b0;
      mon_clear();
      key[0] = 1'b1;
      for (int i = 0; i < 12; i++) begin
        if (i == 2) key[0] = 1'b0;
        tick();
        if (state_dbg == 2'd3) saw_rw = 1'b1;
        if (key_pressed !== 1'b1) dropped = 1'b1;
      end
      chk("relb_saw_rw",   {31'd0, saw_rw},  32'd1);
      chk("relb_dropped",  {31'd0, dropped}, 32'd0);
      chk("relb_strobes",  strobes, 0);
      chk("relb_state",    {30'd0, state_dbg}, 32'd2);
      chk("relb_count",    {28'd0, press_count}, 32'd2);
    end
    key[0] = 1'b1;
    ticks(10);
    chk("relb_idle", {30'd0, state_dbg}, 32'd0);

    // --- wrap: 16 clean presses from 0 ---
    do_reset();
    mon_clear();
    for (int p = 0; p < 16; p++) begin
      press_once();
      if (p == 14) chk("wrap_count15", {28'd0, press_count}, 32'd15);
    end
    chk("wrap_strobes", strobes, 16);
    chk("wrap_consec",  consec, 0);
    chk("wrap_count0",  {28'd0, press_count}, 32'd0);

    // --- reset during PRESS_WAIT with press_count=5 ---
    do_reset();
    for (int p = 0; p < 5; p++) press_once();
    chk("pre_rst_count", {28'd0, press_count}, 32'd5);
    mon_clear();
    key[0] = 1'b0;
    ticks(3);
    chk("mid_state_pw", {30'd0, state_dbg}, 32'd1);
    #2 key[1] = 1'b0;
    #1;
    chk("arst_state",   {30'd0, state_dbg},   32'd0);
    chk("arst_count",   {28'd0, press_count}, 32'd0);
    chk("arst_pressed", {31'd0, key_pressed}, 32'd0);
    chk("arst_pulse",   {31'd0, press_pulse}, 32'd0);
    ticks(10);
    chk("arst_strobes", strobes, 0);
    chk("arst_hold_state", {30'd0, state_dbg}, 32'd0);
    // release reset with the key still held: debounced afresh, one strobe
    key[1] = 1'b1;
    mon_clear();
    ticks(14);
    chk("fresh_strobes", strobes, 1);
    if (s_edges.size() > 0) chk("fresh_edge", s_edges[0], 6);
    else chk("fresh_edge_missing", 0, 1);
    chk("fresh_count", {28'd0, press_count}, 32'd1);
    key[0] = 1'b1;
    ticks(10);

    // --- reset while HELD aborts with no strobe ---
    key[0] = 1'b0;
    ticks(9);
    chk("held_before_rst", {30'd0, state_dbg}, 32'd2);
    mon_clear();
    #2 key[1] = 1'b0;
    key[0] = 1'b1;
    #1;
    chk("held_rst_pressed", {31'd0, key_pressed}, 32'd0);
    ticks(3);
    key[1] = 1'b1;
    ticks(10);
    chk("held_rst_strobes", strobes, 0);
    chk("held_rst_count", {28'd0, press_count}, 32'd0);

    // --- autorepeat / single strobe on a long hold ---
    mon_clear();
    key[0] = 1'b0;
    ticks(7);        // HELD entered at edge 6
    ticks(28);       // held in HELD, then released
    key[0] = 1'b1;
    ticks(15);
    chk("hold_idle", {30'd0, state_dbg}, 32'd0);
    chk("hold_consec", consec, 0);
`ifdef KEY_AUTOREPEAT_EN
    chk("rep_strobes", strobes, 4);
    chk("rep_count", {28'd0, press_count}, 32'd4);
    if (s_edges.size() == 4) begin
      chk("rep_first", s_edges[0], 6);
      for (int i = 1; i < 4; i++)
        chk($sformatf("rep_gap%0d", i), s_edges[i] - s_edges[i-1], RC);
    end else begin
      chk("rep_edges_size", s_edges.size(), 4);
    end
`else
    chk("norep_strobes", strobes, 1);
    chk("norep_count", {28'd0, press_count}, 32'd1);
    if (s_edges.size() > 0) chk("norep_first", s_edges[0], 6);
    else chk("norep_first_missing", 0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the whole run is bounded
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of stable clocks (10 ms at 50 MHz) required to accept a key level change; legal range 2 and up.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 25000000, meaning the held-key repeat period in clocks (used only with KEY_AUTOREPEAT_EN); legal range 2 and up.
REQ-003 SHALL have port CLOCK_50, input, 1 bit: the single system clock, rising-edge active.
REQ-004 SHALL have port KEY, input, 2 bits: KEY[1] is the asynchronous active-low reset; KEY[0] is the raw active-low pushbutton, asynchronous to CLOCK_50.
REQ-005 SHALL have port key_pressed, output, 1 bit: debounced key level, 1 = held.
REQ-006 SHALL have port press_pulse, output, 1 bit: one-clock strobe per accepted press (and per repeat, if enabled), for a downstream stage's enable.
REQ-007 SHALL have port press_count, output, 4 bits: count of strobes issued, wrapping.
REQ-008 SHALL have port state_dbg, output, 2 bits: current FSM state encoding.

Function
REQ-009 SHALL pass KEY[0] through a two-flop synchronizer; all other logic SHALL use only the synchronized value key_s (0 = pressed).
REQ-010 SHALL implement the FSM states IDLE=00, PRESS_WAIT=01, HELD=10 and RELEASE_WAIT=11, driven on state_dbg.
REQ-011 SHALL use one debounce counter of width clog2(DEBOUNCE_CYCLES), cleared on every state entry.
REQ-012 IDLE: if key_s=0, SHALL go to PRESS_WAIT; otherwise remain.
REQ-013 PRESS_WAIT: if key_s=1, SHALL return to IDLE with no strobe; if counter=DEBOUNCE_CYCLES-1, SHALL go to HELD; otherwise SHALL increment the counter.
REQ-014 On the PRESS_WAIT->HELD transition, SHALL assert press_pulse for exactly one clock, set key_pressed=1, and increment press_count in the same clock.
REQ-015 HELD: if key_s=1, SHALL go to RELEASE_WAIT; otherwise remain.
REQ-016 RELEASE_WAIT: if key_s=0, SHALL return to HELD with no new strobe; if counter=DEBOUNCE_CYCLES-1, SHALL go to IDLE and clear key_pressed; otherwise SHALL increment the counter.
REQ-017 Latency: with KEY[0] held low and stable, press_pulse SHALL be high on the (DEBOUNCE_CYCLES+3)th rising edge counted from the first edge that samples KEY[0] low; release latency to key_pressed=0 SHALL be identical.
REQ-018 press_count SHALL wrap from 15 to 0 with no flag.
REQ-019 All outputs SHALL be registered, and press_pulse SHALL never be high on two consecutive clocks.
REQ-020 A glitch on KEY[0] shorter than DEBOUNCE_CYCLES clocks SHALL produce no output change.

Reset
REQ-021 KEY[1]=0 SHALL asynchronously force state IDLE, counters 0, both synchronizer flops 1, key_pressed=0, press_pulse=0 and press_count=0.
REQ-022 Reset deassertion SHALL take effect on the next CLOCK_50 edge.
REQ-023 A reset asserted mid-debounce or while HELD SHALL abort with no strobe.
REQ-024 A key still held at reset release SHALL be debounced afresh and SHALL yield one strobe.

Configuration
REQ-025 Macro KEY_AUTOREPEAT_EN, when defined, SHALL add a repeat counter that is cleared on HELD entry; every REPEAT_CYCLES clocks spent in HELD, it SHALL issue one press_pulse and press_count increment, then restart.
REQ-026 The repeat counter SHALL be cleared on entry to RELEASE_WAIT, and a return to HELD from RELEASE_WAIT SHALL restart the repeat period.
REQ-027 Without KEY_AUTOREPEAT_EN, no repeat logic SHALL exist, and exactly one strobe SHALL occur per accepted press.

Verification (bench: DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
REQ-028 Bench SHALL cover a clean press: KEY[0] low at edge 0 and held -> press_pulse high for one clock at edge 7, key_pressed=1, press_count=1.
REQ-029 Bench SHALL cover a bounce: KEY[0] low 2 clocks, high 1 clock, then low and stable -> exactly one strobe, 7 edges after the final fall.
REQ-030 Bench SHALL cover release bounce: while HELD, KEY[0] high 2 clocks then low -> state returns to HELD, no strobe, key_pressed stays 1.
REQ-031 Bench SHALL cover wrap: 16 clean presses -> press_count returns to 0 with 16 single-clock strobes.
REQ-032 Bench SHALL cover reset mid-operation: KEY[1] low during PRESS_WAIT -> all outputs 0 immediately, no strobe; press_count cleared from 5 to 0.
REQ-033 Bench SHALL cover autorepeat: with KEY_AUTOREPEAT_EN, KEY[0] held 30 clocks after HELD entry -> 1 initial plus 3 repeat strobes, 8 clocks apart; without the macro -> 1 strobe only.
